// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port, non-write-through Ram (async read).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to port 0.
module ram_arbiter #(
  parameter  int RAM_DEPTH  = 65536,
  parameter  int WIDTH      = 16,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  i_p0_req,
  input  logic                  i_p0_we,
  input  logic                  i_p0_lock,
  input  logic [ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [WIDTH-1:0]      i_p0_wdata,
  output logic                  o_p0_ack,
  output logic [WIDTH-1:0]      o_p0_rdata,
  input  logic                  i_p1_req,
  input  logic                  i_p1_we,
  input  logic                  i_p1_lock,
  input  logic [ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [WIDTH-1:0]      i_p1_wdata,
  output logic                  o_p1_ack,
  output logic [WIDTH-1:0]      o_p1_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic                  o_ram_load_enable,
  output logic [WIDTH-1:0]      o_ram_load_data,
  input  logic [WIDTH-1:0]      i_ram_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state;
  logic   owner;
  logic   locked;
  logic   last_grant;
  logic   cand0, cand1;
  logic   tie_pick;
  logic   winner;

  // While locked only the owner may win; the other port stalls even if the owner is idle.
  always_comb begin
    cand0 = i_p0_req & (~locked | ~owner);
    cand1 = i_p1_req & (~locked |  owner);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    tie_pick = ~last_grant;
`else
    tie_pick = last_grant & 1'b0;
`endif
    winner = (cand0 & cand1) ? tie_pick : cand1;
  end

  always_comb begin
    o_p0_ack = (state == ACCESS) & clk_en & ~owner;
    o_p1_ack = (state == ACCESS) & clk_en &  owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      owner             <= 1'b0;
      locked            <= 1'b0;
      last_grant        <= 1'b1;
      o_ram_address     <= '0;
      o_ram_load_data   <= '0;
      o_ram_load_enable <= 1'b0;
      o_p0_rdata        <= '0;
      o_p1_rdata        <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (cand0 | cand1) begin
            owner             <= winner;
            last_grant        <= winner;
            o_ram_address     <= winner ? i_p1_addr  : i_p0_addr;
            o_ram_load_data   <= winner ? i_p1_wdata : i_p0_wdata;
            o_ram_load_enable <= winner ? i_p1_we    : i_p0_we;
            state             <= ACCESS;
          end
        end
        ACCESS: begin
          if (owner) begin
            o_p1_rdata <= i_ram_data;
            locked     <= i_p1_lock;
          end else begin
            o_p0_rdata <= i_ram_data;
            locked     <= i_p0_lock;
          end
          o_ram_load_enable <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural Ram plus a reference memory model and per-scenario tasks.
module tb_ram_arbiter;
  localparam int RAM_DEPTH = 65536;
  localparam int WIDTH     = 16;
  localparam int AW        = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clk_en = 1'b1;
  logic req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic ram_le;
  logic [WIDTH-1:0] ram_ld, ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int en_edges = 0;
  int commits = 0;
  bit en_toggle = 0;
  int unsigned en_phase = 0;

  ram_arbiter #(.RAM_DEPTH(RAM_DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .i_p0_req(req0), .i_p0_we(we0), .i_p0_lock(lock0), .i_p0_addr(addr0), .i_p0_wdata(wdata0),
    .o_p0_ack(ack0), .o_p0_rdata(rdata0),
    .i_p1_req(req1), .i_p1_we(we1), .i_p1_lock(lock1), .i_p1_addr(addr1), .i_p1_wdata(wdata1),
    .o_p1_ack(ack1), .o_p1_rdata(rdata1),
    .o_ram_address(ram_addr), .o_ram_load_enable(ram_le), .o_ram_load_data(ram_ld),
    .i_ram_data(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] init_val(input int a);
    logic [15:0] x;
    x = a[15:0];
    if (a == 16'h0010) return 16'h1234;
    return (x * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Ram: asynchronous read, write committed at a clk_en edge while load_enable is high
  logic [WIDTH-1:0] ram [RAM_DEPTH];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) begin
    logic [AW-1:0] a;
    logic [WIDTH-1:0] d;
    if (clk_en) en_edges++;
    if (clk_en && ram_le) begin
      a = ram_addr; d = ram_ld; commits++;
      #1 ram[a] = d;
    end
  end

  always @(posedge clk) begin
    #2;
    if (en_toggle) begin
      clk_en = (en_phase % 3 == 0);
      en_phase++;
    end else clk_en = 1'b1;
  end

  logic [WIDTH-1:0] ref_mem [int];
  function automatic logic [WIDTH-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic apply_reset();
    req0 = 0; req1 = 0;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  // Drives one request and follows it to completion; call right after a negedge.
  task automatic access(input bit port, input bit we, input bit lock, input logic [AW-1:0] addr,
                        input logic [WIDTH-1:0] wdata, output logic [WIDTH-1:0] rd, output bit ok,
                        output int acks, output int les, output int bad, output int lat);
    int e0; bit seen; bit a;
    if (port) begin we1 = we; lock1 = lock; addr1 = addr; wdata1 = wdata; req1 = 1; end
    else      begin we0 = we; lock0 = lock; addr0 = addr; wdata0 = wdata; req0 = 1; end
    e0 = en_edges; acks = 0; les = 0; bad = 0; ok = 0; seen = 0; rd = '0; lat = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      a = port ? ack1 : ack0;
      if (a) acks++;
      if (ram_le) les++;
      if ((ack0 || ack1) && !clk_en) bad++;
      if (ack0 && ack1) bad++;
      if (seen) begin
        rd = port ? rdata1 : rdata0; lat = en_edges - e0; ok = 1;
      end else if (a) seen = 1;
    end
    if (port) req1 = 0; else req0 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1; #1; rst_n = 0; #1;
    n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", ram_addr); end
    n_cmp++; if (ram_ld !== '0) begin n_bad++; $display("FAIL reset_ld: got %h want 0000", ram_ld); end
    n_cmp++; if (ram_le !== 1'b0) begin n_bad++; $display("FAIL reset_le: got %b want 0", ram_le); end
    n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", {ack0, ack1}); end
    n_cmp++; if ({rdata0, rdata1} !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 0", rdata0, rdata1); end
    @(negedge clk); @(negedge clk); rst_n = 1;
  endtask

  task automatic test_read();
    we0 = 0; lock0 = 0; addr0 = 16'h0010; req0 = 1;
    @(negedge clk);
    n_cmp++; if (ram_addr !== 16'h0010) begin n_bad++; $display("FAIL read_addr: got %h want 0010", ram_addr); end
    n_cmp++; if (ack0 !== 1'b1) begin n_bad++; $display("FAIL read_ack_on: got %b want 1", ack0); end
    n_cmp++; if (ram_le !== 1'b0) begin n_bad++; $display("FAIL read_le: got %b want 0", ram_le); end
    @(negedge clk);
    n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL read_ack_off: got %b want 0", ack0); end
    n_cmp++; if (rdata0 !== 16'h1234) begin n_bad++; $display("FAIL read_data: got %h want 1234", rdata0); end
    req0 = 0;
  endtask

  task automatic test_write_read();
    logic [WIDTH-1:0] rd; bit ok; int acks, les, bad, lat, c0;
    c0 = commits;
    access(1, 1, 0, 16'h0020, 16'hBEEF, rd, ok, acks, les, bad, lat);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wr_done: got %b want 1", ok); end
    n_cmp++; if (rd !== ref_rd(16'h0020)) begin n_bad++; $display("FAIL wr_old: got %h want %h", rd, ref_rd(16'h0020)); end
    n_cmp++; if (les !== 1) begin n_bad++; $display("FAIL wr_le_cycles: got %0d want 1", les); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
    n_cmp++; if (commits - c0 !== 1) begin n_bad++; $display("FAIL wr_commits: got %0d want 1", commits - c0); end
    ref_mem[16'h0020] = 16'hBEEF;
    access(1, 0, 0, 16'h0020, 16'h0000, rd, ok, acks, les, bad, lat);
    n_cmp++; if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL rd_back: got %h want beef", rd); end
    n_cmp++; if (les !== 0) begin n_bad++; $display("FAIL rd_le_cycles: got %0d want 0", les); end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL rd_ack_cycles: got %0d want 1", acks); end
  endtask

  task automatic test_contention();
    int g[$]; bit d0, d1; int got, want;
    apply_reset();
    we0 = 0; lock0 = 0; addr0 = 16'h0011; we1 = 0; lock1 = 0; addr1 = 16'h0012;
    req0 = 1; req1 = 1; d0 = 0; d1 = 0;
    for (int i = 0; i < 60 && (req0 || req1); i++) begin
      @(negedge clk);
      if (d0) begin req0 = 0; d0 = 0; end
      if (d1) begin req1 = 0; d1 = 0; end
      if (ack0) begin g.push_back(0); if (g.size() >= 4) d0 = 1; end
      if (ack1) begin g.push_back(1); if (g.size() >= 4) d1 = 1; end
    end
    n_cmp++; if (req0 || req1) begin n_bad++; $display("FAIL cont_timeout: got %b%b want 00", req0, req1); end
    req0 = 0; req1 = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      want = k % 2;
`else
      want = 0;
`endif
      got = (k < g.size()) ? g[k] : -1;
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL cont_grant%0d: got %0d want %0d", k, got, want); end
    end
    n_cmp++; if (g.size() !== 5) begin n_bad++; $display("FAIL cont_count: got %0d want 5", g.size()); end
  endtask

  task automatic test_lock();
    logic [WIDTH-1:0] rd, old; int stall; bit got;
    old = ref_rd(16'h0030);
    we0 = 0; lock0 = 1; addr0 = 16'h0030; req0 = 1;
    @(negedge clk);
    n_cmp++; if (ack0 !== 1'b1) begin n_bad++; $display("FAIL lock_rd_ack: got %b want 1", ack0); end
    we1 = 0; lock1 = 0; addr1 = 16'h0050; req1 = 1;
    @(negedge clk);
    rd = rdata0; req0 = 0;
    n_cmp++; if (rd !== old) begin n_bad++; $display("FAIL lock_rd_data: got %h want %h", rd, old); end
    stall = 0;
    repeat (4) begin @(negedge clk); if (ack1) stall++; end
    n_cmp++; if (stall !== 0) begin n_bad++; $display("FAIL lock_stall: got %0d acks want 0", stall); end
    we0 = 1; lock0 = 0; wdata0 = rd + 16'd1; req0 = 1;
    @(negedge clk);
    n_cmp++; if ({ack0, ack1} !== 2'b10) begin n_bad++; $display("FAIL lock_wr_ack: got %b want 10", {ack0, ack1}); end
    @(negedge clk);
    req0 = 0;
    ref_mem[16'h0030] = old + 16'd1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); if (ack1) got = 1; end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL lock_p1_ack: got %b want 1", got); end
    @(negedge clk);
    req1 = 0;
    n_cmp++; if (rdata1 !== ref_rd(16'h0050)) begin n_bad++; $display("FAIL lock_p1_data: got %h want %h", rdata1, ref_rd(16'h0050)); end
    n_cmp++; if (ram[16'h0030] !== old + 16'd1) begin n_bad++; $display("FAIL lock_rmw: got %h want %h", ram[16'h0030], old + 16'd1); end
  endtask

  task automatic test_clk_en();
    logic [WIDTH-1:0] rd, wd; bit ok; int acks, les, bad, lat, c0;
    wd = 16'($urandom);
    en_toggle = 1;
    @(negedge clk); @(negedge clk);
    c0 = commits;
    access(1, 1, 0, 16'h0060, wd, rd, ok, acks, les, bad, lat);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL en_done: got %b want 1", ok); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL en_ack_gated: got %0d want 0", bad); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL en_latency: got %0d want 2", lat); end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL en_ack_cycles: got %0d want 1", acks); end
    n_cmp++; if (rd !== ref_rd(16'h0060)) begin n_bad++; $display("FAIL en_old: got %h want %h", rd, ref_rd(16'h0060)); end
    n_cmp++; if (commits - c0 !== 1) begin n_bad++; $display("FAIL en_commits: got %0d want 1", commits - c0); end
    ref_mem[16'h0060] = wd;
    n_cmp++; if (ram[16'h0060] !== wd) begin n_bad++; $display("FAIL en_mem: got %h want %h", ram[16'h0060], wd); end
    en_toggle = 0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got;
    we0 = 1; lock0 = 0; addr0 = 16'h0040; wdata0 = 16'hDEAD; req0 = 1;
    @(negedge clk);
    n_cmp++; if ({ack0, ram_le} !== 2'b11) begin n_bad++; $display("FAIL rm_access: got %b want 11", {ack0, ram_le}); end
    rst_n = 0; #1;
    n_cmp++; if (ram_le !== 1'b0) begin n_bad++; $display("FAIL rm_le: got %b want 0", ram_le); end
    n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_bad++; $display("FAIL rm_ack: got %b want 00", {ack0, ack1}); end
    n_cmp++; if ({ram_addr, ram_ld} !== '0) begin n_bad++; $display("FAIL rm_ram_out: got %h/%h want 0", ram_addr, ram_ld); end
    n_cmp++; if ({rdata0, rdata1} !== '0) begin n_bad++; $display("FAIL rm_rdata: got %h/%h want 0", rdata0, rdata1); end
    @(negedge clk);
    rst_n = 1; req0 = 0;
    n_cmp++; if (ram[16'h0040] !== ref_rd(16'h0040)) begin n_bad++; $display("FAIL rm_mem: got %h want %h", ram[16'h0040], ref_rd(16'h0040)); end
    we0 = 0; addr0 = 16'h0041; we1 = 0; lock1 = 0; addr1 = 16'h0042; req0 = 1; req1 = 1;
    @(negedge clk);
    n_cmp++; if ({ack0, ack1} !== 2'b10) begin n_bad++; $display("FAIL rm_first_tie: got %b want 10", {ack0, ack1}); end
    @(negedge clk);
    req0 = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); if (ack1) got = 1; end
    @(negedge clk);
    req1 = 0;
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rm_p1_after: got %b want 1", got); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] rd, wd, exp; logic [AW-1:0] a; bit ok, port, we; int acks, les, bad, lat;
    for (int n = 0; n < 40; n++) begin
      port = 1'($urandom); we = 1'($urandom);
      a = 16'($urandom_range(16'h0100, 16'h010F)); wd = 16'($urandom);
      exp = ref_rd(a);
      access(port, we, 0, a, wd, rd, ok, acks, les, bad, lat);
      n_cmp++; if (!ok || rd !== exp) begin n_bad++; $display("FAIL rnd_%0d p%0d we%0d @%h: got %h ok=%b want %h", n, port, we, a, rd, ok, exp); end
      if (we) ref_mem[a] = wd;
    end
    for (int a2 = 16'h0100; a2 <= 16'h010F; a2++) begin
      n_cmp++; if (ram[a2] !== ref_rd(a2)) begin n_bad++; $display("FAIL rnd_mem @%h: got %h want %h", a2, ram[a2], ref_rd(a2)); end
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = init_val(i);
    test_reset();
    test_read();
    test_write_read();
    test_contention();
    test_lock();
    test_clk_en();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
